// File: rtl/count_seq_checker.sv
// Receive-side monitor for a MIN..MAX wrapping 4-bit sequence counter.
// Hunts for an in-range value, acquires LOCK_N correct steps, then flags breaks with a flywheel.
module count_seq_checker #(
    parameter logic [3:0] MIN      = 4'd3,
    parameter logic [3:0] MAX      = 4'd13,
    parameter int         LOCK_N   = 4,
    parameter int         UNLOCK_N = 2,
    parameter int         ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       q_in,
    input  logic             err_clr,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [ERR_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] CNT_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [4:0]       LOCK_L  = 5'(LOCK_N);
    localparam logic [4:0]       UNLK_L  = 5'(UNLOCK_N);

    state_t           state_q, state_d;
    logic [3:0]       prev_q, prev_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       miss_q, miss_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;

    logic [3:0] expect_v;
    logic       in_range;
    logic [4:0] run_inc;
    logic [4:0] miss_inc;

    function automatic logic [3:0] nxt(input logic [3:0] x);
        return (x == MAX) ? MIN : x + 4'd1;
    endfunction

    assign expect_v = nxt(prev_q);
    assign in_range = (q_in >= MIN) && (q_in <= MAX);
    assign run_inc  = {1'b0, run_q} + 5'd1;
    assign miss_inc = {1'b0, miss_q} + 5'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            prev_q      <= 4'd0;
            run_q       <= 4'd0;
            miss_q      <= 4'd0;
            err_count_q <= '0;
            err_q       <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            err_count_q <= err_count_d;
            err_q       <= err_d;
            wrap_q      <= wrap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        run_d       = run_q;
        miss_d      = miss_q;
        err_count_d = err_count_q;
        err_d       = 1'b0;
        wrap_d      = 1'b0;
        if (en) begin
            case (state_q)
                HUNT: begin
                    if (in_range) begin
                        prev_d  = q_in;
                        run_d   = 4'd0;
                        state_d = ACQ;
                    end
                end
                ACQ: begin
                    if (q_in == expect_v) begin
                        prev_d = q_in;
                        run_d  = run_inc[3:0];
                        if (run_inc == LOCK_L) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else if (in_range) begin
                        prev_d = q_in;
                        run_d  = 4'd0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (q_in == expect_v) begin
                        prev_d = q_in;
                        miss_d = 4'd0;
                        wrap_d = (prev_q == MAX);
                    end else begin
                        // Flywheel: treat the sample as a glitch and advance the expected value.
                        err_d  = 1'b1;
                        prev_d = expect_v;
                        miss_d = miss_inc[3:0];
                        if (err_count_q != CNT_MAX) begin
                            err_count_d = err_count_q + CNT_ONE;
                        end
                        if (miss_inc == UNLK_L) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
            if (err_clr) begin
                err_count_d = '0;
            end
        end
    end

    always_comb begin
        locked      = (state_q == LOCKED);
        err         = err_q;
        wrap        = wrap_q;
        err_count   = err_count_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: default instance plus a small-counter instance for saturation,
// each checked every cycle against a sequence model, with directed literal checks.
module tb_count_seq_checker;

    localparam int MIN_V = 3;
    localparam int MAX_V = 13;

    logic       clk = 1'b0;
    logic       reset;
    logic       en_a, clr_a, en_b, clr_b;
    logic [3:0] q_a, q_b;
    logic       locked_a, err_a, wrap_a, locked_b, err_b, wrap_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [1:0] dbg_a, dbg_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        bit lk;
        int streak;
        int last;
        int misses;
        int errs;
        bit e;
        bit w;
    } mdl_t;

    mdl_t ma, mb;

    always #5 clk = ~clk;

    count_seq_checker dut_a (
        .clk(clk), .reset(reset), .en(en_a), .q_in(q_a), .err_clr(clr_a),
        .locked(locked_a), .err(err_a), .wrap(wrap_a), .err_count(cnt_a),
        .dbg_state_o(dbg_a)
    );

    count_seq_checker #(.UNLOCK_N(15), .ERR_W(2)) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .q_in(q_b), .err_clr(clr_b),
        .locked(locked_b), .err(err_b), .wrap(wrap_b), .err_count(cnt_b),
        .dbg_state_o(dbg_b)
    );

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.lk = 0; r.streak = -1; r.last = 0; r.misses = 0; r.errs = 0; r.e = 0; r.w = 0;
        return r;
    endfunction

    // streak < 0 means still hunting; the expected value is the cyclic successor within MIN..MAX.
    function automatic mdl_t step(mdl_t m, bit e, int q, bit c, int lock_n, int unlock_n, int cmax);
        mdl_t r;
        int   nx;
        bit   inr;
        r = m;
        r.e = 0;
        r.w = 0;
        if (!e) return r;
        inr = (q >= MIN_V) && (q <= MAX_V);
        nx  = MIN_V + ((m.last - MIN_V + 1) % (MAX_V - MIN_V + 1));
        if (m.lk) begin
            if (q == nx) begin
                r.w = (nx == MIN_V);
                r.last = q;
                r.misses = 0;
            end else begin
                r.e = 1;
                r.errs = (m.errs < cmax) ? m.errs + 1 : cmax;
                r.last = nx;
                r.misses = m.misses + 1;
                if (r.misses == unlock_n) begin
                    r.lk = 0;
                    r.streak = -1;
                end
            end
        end else if (m.streak < 0) begin
            if (inr) begin
                r.streak = 0;
                r.last = q;
            end
        end else begin
            if (q == nx) begin
                r.last = q;
                r.streak = m.streak + 1;
                if (r.streak == lock_n) begin
                    r.lk = 1;
                    r.misses = 0;
                end
            end else if (inr) begin
                r.last = q;
                r.streak = 0;
            end else begin
                r.streak = -1;
            end
        end
        if (c) r.errs = 0;
        return r;
    endfunction

    initial begin
        ma = mdl_reset();
        mb = mdl_reset();
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma <= mdl_reset();
            mb <= mdl_reset();
        end else begin
            ma <= step(ma, en_a, int'(q_a), clr_a, 4, 2, 255);
            mb <= step(mb, en_b, int'(q_b), clr_b, 4, 15, 3);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("a.locked", int'(locked_a), int'(ma.lk));
        check("a.err", int'(err_a), int'(ma.e));
        check("a.wrap", int'(wrap_a), int'(ma.w));
        check("a.err_count", int'(cnt_a), ma.errs);
        check("b.locked", int'(locked_b), int'(mb.lk));
        check("b.err", int'(err_b), int'(mb.e));
        check("b.wrap", int'(wrap_b), int'(mb.w));
        check("b.err_count", int'(cnt_b), mb.errs);
    end

    task automatic apply_a(input bit e, input logic [3:0] q, input bit c);
        en_a = e; q_a = q; clr_a = c;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_b(input bit e, input logic [3:0] q, input bit c);
        en_b = e; q_b = q; clr_b = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        logic [7:0] exp_cnt;
        reset = 1'b1;
        en_a = 0; q_a = 0; clr_a = 0;
        en_b = 0; q_b = 0; clr_b = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.locked", int'(locked_a), 0);
        check("reset.err_count", int'(cnt_a), 0);
        reset = 1'b0;

        // Lock from reset: locked only after the fifth sample.
        apply_a(1, 4'd3, 0); check("lock.s1", int'(locked_a), 0);
        apply_a(1, 4'd4, 0); check("lock.s2", int'(locked_a), 0);
        apply_a(1, 4'd5, 0); check("lock.s3", int'(locked_a), 0);
        apply_a(1, 4'd6, 0); check("lock.s4", int'(locked_a), 0);
        apply_a(1, 4'd7, 0); check("lock.s5", int'(locked_a), 1);
        check("lock.err", int'(err_a), 0);

        // Single glitch at prev=7.
        apply_a(1, 4'd8, 0);  check("glitch.err8", int'(err_a), 0);
        apply_a(1, 4'd0, 0);  check("glitch.err0", int'(err_a), 1);
        check("glitch.cnt", int'(cnt_a), 1);
        apply_a(1, 4'd10, 0); check("glitch.err10", int'(err_a), 0);
        apply_a(1, 4'd11, 0); check("glitch.locked", int'(locked_a), 1);
        check("glitch.cnt_end", int'(cnt_a), 1);

        // Wrap.
        apply_a(1, 4'd12, 0); check("wrap.12", int'(wrap_a), 0);
        apply_a(1, 4'd13, 0); check("wrap.13", int'(wrap_a), 0);
        apply_a(1, 4'd3, 0);  check("wrap.3", int'(wrap_a), 1);
        check("wrap.err", int'(err_a), 0);
        apply_a(1, 4'd4, 0);  check("wrap.4", int'(wrap_a), 0);
        check("wrap.cnt", int'(cnt_a), 1);

        // Clear on a good sample, then unlock with two bad samples.
        apply_a(1, 4'd5, 1); check("clr.cnt", int'(cnt_a), 0);
        check("clr.err", int'(err_a), 0);
        apply_a(1, 4'd2, 0); check("unlock.err1", int'(err_a), 1);
        check("unlock.cnt1", int'(cnt_a), 1);
        check("unlock.locked1", int'(locked_a), 1);
        apply_a(1, 4'd2, 0); check("unlock.err2", int'(err_a), 1);
        check("unlock.cnt2", int'(cnt_a), 2);
        check("unlock.locked2", int'(locked_a), 0);
        apply_a(1, 4'd15, 0); check("hunt.15", int'(locked_a), 0);
        check("hunt.err", int'(err_a), 0);
        apply_a(1, 4'd5, 0);
        apply_a(1, 4'd6, 0);
        apply_a(1, 4'd7, 0);
        apply_a(1, 4'd8, 0); check("relock.8", int'(locked_a), 0);
        apply_a(1, 4'd9, 0); check("relock.9", int'(locked_a), 1);

        // en gating with garbage on q_in.
        apply_a(0, 4'd0, 0);  check("gate.locked0", int'(locked_a), 1);
        apply_a(0, 4'd15, 0); check("gate.err", int'(err_a), 0);
        apply_a(0, 4'd2, 0);  check("gate.cnt", int'(cnt_a), 2);
        apply_a(1, 4'd10, 0); check("gate.resume_err", int'(err_a), 0);
        check("gate.resume_locked", int'(locked_a), 1);

        // Asynchronous reset mid-cycle.
        #2;
        reset = 1'b1;
        #1;
        check("areset.locked", int'(locked_a), 0);
        check("areset.cnt", int'(cnt_a), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply_a(1, 4'd3, 0); check("post_reset.locked", int'(locked_a), 0);
        apply_a(0, 4'd0, 0);

        // Saturation on the 2-bit counter instance.
        apply_b(1, 4'd3, 0);
        apply_b(1, 4'd4, 0);
        apply_b(1, 4'd5, 0);
        apply_b(1, 4'd6, 0);
        apply_b(1, 4'd7, 0); check("sat.locked", int'(locked_b), 1);
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd2);
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd3);
        while (exp_q.size() > 0) begin
            exp_cnt = exp_q.pop_front();
            apply_b(1, 4'd0, 0);
            check("sat.err", int'(err_b), 1);
            check("sat.cnt", int'(cnt_b), int'(exp_cnt));
        end
        apply_b(1, 4'd0, 1);
        check("sat.clr_err", int'(err_b), 1);
        check("sat.clr_cnt", int'(cnt_b), 0);
        check("sat.still_locked", int'(locked_b), 1);
        apply_b(0, 4'd0, 0);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
